bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
- Sits between the ALU result register and the 7-segment display multiplexer.
- Takes the 8-bit ALU result on a start strobe and delivers packed BCD digits, so the display shows decimal rather than hex.
- One shift per clock; start/busy/done handshake.

Parameters:
- WIDTH, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; no overflow detection.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  WIDTH  binary value; captured on the accepted start edge only.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle completion pulse.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0]; holds last result.
- neg  output  1  sign of last result (see Optional Feature).

Behaviour:
- Reset (async, active-high): state = IDLE; busy=0, done=0, bcd_out=0, neg=0; scratch and counter cleared. Reset mid-conversion aborts immediately; no done pulse follows.
- Internal registers:
  - Scratch register: 4*DIGITS BCD bits concatenated with WIDTH binary bits.
  - Iteration counter: ceil(log2(WIDTH+1)) bits.
- States: IDLE, SHIFT.
- IDLE:
  - done is forced to 0 on every edge unless a completion occurs on that edge.
  - If start=1 at edge k: load BCD part of scratch = 0 and binary part = bin_in; counter = 0; go to SHIFT; busy=1 after edge k.
- SHIFT, each edge:
  - Every BCD digit of the scratch that is >= 5 has 3 added, combinationally from the current scratch.
  - The adjusted scratch is shifted left by 1, then counter increments.
- Completion: the edge performing shift number WIDTH (edge k+WIDTH) also:
  - writes bcd_out = final BCD part;
  - sets done=1 and busy=0;
  - returns to IDLE.
- Timing:
  - done is high for exactly the one cycle after edge k+WIDTH.
  - Latency from start edge to valid bcd_out/done = WIDTH clocks (8 by default).
- Handshake rules:
  - start while busy=1 is ignored; no queueing.
  - start=1 while done=1 (state already IDLE) is accepted: back-to-back conversions, one every WIDTH+1 clocks.
  - start held high continuously re-triggers on each IDLE cycle.
  - bin_in changes during SHIFT have no effect on the current result.
  - bcd_out and neg change only on completion edges (and reset).
- Boundary values:
  - bin_in=0 gives all-zero digits.
  - bin_in = 2^WIDTH-1 must convert exactly, e.g. 255 gives digits 2,5,5.

Optional Feature:
- Macro: BIN_TO_BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - At the accepted start edge, if bin_in[WIDTH-1]=1, the binary part loads -bin_in (computed in WIDTH bits, read as unsigned) and a pending sign flag = 1; otherwise the flag = 0.
  - neg is updated from the pending flag on the completion edge.
  - Most-negative input: 0x80 gives magnitude 128, neg=1.
- Not defined:
  - Input is unsigned; neg is tied to 0.
  - No sign logic is synthesized; the port list is unchanged.

Test Plan:
- Reset, then start with bin_in=8'd0 → done pulses exactly 8 clocks after the start edge, bcd_out=12'h000, busy high for the 8 intervening cycles.
- bin_in=8'd255 → bcd_out=12'h255. Then bin_in=8'd99 → 12'h099; bin_in=8'd100 → 12'h100; bin_in=8'd9 → 12'h009.
- Start with 8'd37, hold start high, and change bin_in to 8'd200 during busy → first result 12'h037. The re-trigger is accepted on the done cycle and samples 200, so second result 12'h200 after a further 8 clocks; no extra done pulses.
- Start with 8'd123, assert reset 4 clocks later for 1 cycle → busy=0, done never asserted, bcd_out=12'h000. A new start with 8'd45 yields 12'h045.
- Without the macro, bin_in=8'hF6 → bcd_out=12'h246, neg=0. With BIN_TO_BCD_SIGNED_EN, 8'hF6 → 12'h010, neg=1; 8'h80 → 12'h128, neg=1; 8'h7F → 12'h127, neg=0.
- Exhaustive sweep of 0..255 back-to-back (start asserted on each done cycle) → each bcd_out matches the decimal reference model, one result per 9 clocks.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BIN_TO_BCD_SIGNED_EN to treat bin_in as two's complement and report the sign on neg.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg
);

  localparam int BW = 4*DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH+1);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  logic          r_state;
  logic [SW-1:0] r_scr;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] w_adj;
  logic [SW-1:0] w_shift;
  logic [WIDTH-1:0] w_mag;
  logic          w_last;

  // Add-3 correction on every digit >= 5, then the shift for this cycle.
  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[WIDTH+4*d +: 4] >= 4'd5)
        w_adj[WIDTH+4*d +: 4] = r_scr[WIDTH+4*d +: 4] + 4'd3;
    end
    w_shift = w_adj << 1;
  end

  assign w_last = (r_cnt == CW'(WIDTH-1));

`ifdef BIN_TO_BCD_SIGNED_EN
  logic r_pend;
  // Magnitude of the two's-complement input; -MIN wraps to 2^(WIDTH-1) read unsigned.
  assign w_mag = bin_in[WIDTH-1] ? (~bin_in + 1'b1) : bin_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= 1'b0;
      neg    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) r_pend <= bin_in[WIDTH-1];
    end else if (w_last) begin
      neg <= r_pend;
    end
  end
`else
  assign w_mag = bin_in;
  assign neg   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_scr   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_scr   <= {{BW{1'b0}}, w_mag};
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        default: begin
          r_scr <= w_shift;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            bcd_out <= w_shift[SW-1:WIDTH];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, scoreboard queue, handshake corner cases.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        neg;

  int checks   = 0;
  int failures = 0;
  int dones    = 0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        n;
  } vec_t;

  typedef struct {
    logic [11:0] bcd;
    logic        n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference model, independent of the shift-and-add algorithm.
  function automatic exp_t model(input logic [7:0] v);
    exp_t e;
    int   m;
    m   = int'(v);
    e.n = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    if (v[7]) begin
      m   = 256 - int'(v);
      e.n = 1'b1;
    end
`endif
    e.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0h expected=no_done", bcd_out);
      end else begin
        mon_e = sb.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
        chk("neg", 32'(neg), 32'(mon_e.n));
      end
    end
  end

  // Waits for done after an accepted start edge; done must appear exactly 8 clocks later.
  task automatic wait_done(input bit chk_busy);
    bit seen = 1'b0;
    int lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (chk_busy) begin
        chk("busy_during_conv", 32'(busy), 32'd1);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done_within_20");
    end else begin
      chk("latency", 32'(lat), 32'd8);
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_one(input logic [7:0] v, input bit chk_busy);
    start  = 1'b1;
    bin_in = v;
    sb.push_back(model(v));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(chk_busy);
  endtask

  initial begin
    int d0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;

`ifdef BIN_TO_BCD_SIGNED_EN
    vecs.push_back('{8'hF6, 12'h010, 1'b1});
    vecs.push_back('{8'h80, 12'h128, 1'b1});
    vecs.push_back('{8'h7F, 12'h127, 1'b0});
    vecs.push_back('{8'hFF, 12'h001, 1'b1});
    vecs.push_back('{8'd99, 12'h099, 1'b0});
    vecs.push_back('{8'd100, 12'h100, 1'b0});
    vecs.push_back('{8'd9, 12'h009, 1'b0});
`else
    vecs.push_back('{8'd255, 12'h255, 1'b0});
    vecs.push_back('{8'd99, 12'h099, 1'b0});
    vecs.push_back('{8'd100, 12'h100, 1'b0});
    vecs.push_back('{8'd9, 12'h009, 1'b0});
    vecs.push_back('{8'hF6, 12'h246, 1'b0});
    vecs.push_back('{8'h80, 12'h128, 1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero with busy checked across the whole conversion.
    start  = 1'b1;
    bin_in = 8'd0;
    sb.push_back('{12'h000, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(1'b1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    foreach (vecs[i]) begin
      start  = 1'b1;
      bin_in = vecs[i].bin;
      sb.push_back('{vecs[i].bcd, vecs[i].n});
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0);
    end
    repeat (2) @(posedge clk);
    #1;

    // Start held high; bin_in changes mid-conversion; re-trigger on the done cycle.
    d0     = dones;
    start  = 1'b1;
    bin_in = 8'd37;
    sb.push_back(model(8'd37));
    @(posedge clk); #1;
    bin_in = 8'd200;
    sb.push_back(model(8'd200));
    wait_done(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("retrigger_busy", 32'(busy), 32'd1);
    wait_done(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("held_start_done_count", 32'(dones - d0), 32'd2);

    // Reset four clocks into a conversion aborts it silently.
    d0     = dones;
    start  = 1'b1;
    bin_in = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(dones - d0), 32'd0);
    run_one(8'd45, 1'b1);

    // Back-to-back sweep of every input value.
    for (int v = 0; v < 256; v++) run_one(8'(v), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
